// File: rtl/ref_dds_gen.sv
// Lock-in reference DDS: phase accumulator, quarter-wave sine ROM, amplitude shift, DAC drive.
// Optional phase dither is enabled by defining REF_DITHER_EN.
module ref_dds_gen #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              reffreq,
  input  logic [1:0]              refampl,
  input  logic                    refIO,
  output logic signed [OUT_W-1:0] sin_o,
  output logic signed [OUT_W-1:0] cos_o,
  output logic [OUT_W-1:0]        dac_o,
  output logic                    valid_o,
  output logic                    sync_o
);

  localparam int TOP_W = LUT_AW + 2;
  localparam int LUT_N = 1 << LUT_AW;
  localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

  // Tuning words are f * 2^32 / 30 MHz; a PLL change needs a new table.
  function automatic logic [PHASE_W-1:0] ftw_lookup(input logic [2:0] sel);
    logic [31:0] f;
    f = 32'd14316558;
    case (sel)
      3'd0: f = 32'd1432;
      3'd1: f = 32'd2863;
      3'd2: f = 32'd7158;
      3'd3: f = 32'd14317;
      3'd4: f = 32'd71583;
      3'd5: f = 32'd143166;
      3'd6: f = 32'd1431656;
      default: f = 32'd14316558;
    endcase
    return PHASE_W'(f);
  endfunction

  // Quarter-wave entry round(FS * sin(pi/2 * (i + 0.5) / N)) via Q30 Taylor series.
  function automatic logic [OUT_W-1:0] lut_entry(input int i);
    longint half_pi, x, x2, term, sum, fs;
    half_pi = 64'sd1686629713;
    fs      = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    x       = (half_pi * longint'(2 * i + 1) + longint'(LUT_N)) / longint'(2 * LUT_N);
    x2      = (x * x) >>> 30;
    term    = x;
    sum     = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return OUT_W'((sum * fs + (64'sd1 <<< 29)) >>> 30);
  endfunction

  // Returns {negate, rom_address} for the top phase bits.
  function automatic logic [LUT_AW:0] fold(input logic [TOP_W-1:0] top);
    logic [LUT_AW-1:0] a;
    a = top[LUT_AW-1:0];
    if (top[LUT_AW]) a = ~a;
    return {top[LUT_AW+1], a};
  endfunction

  function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-1:0] mag,
                                                         input logic neg);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic signed [OUT_W-1:0] attenuate(input logic signed [OUT_W-1:0] s,
                                                        input logic [1:0] sh);
    return s >>> sh;
  endfunction

  function automatic logic [OUT_W-1:0] to_offset_bin(input logic signed [OUT_W-1:0] s);
    return {~s[OUT_W-1], s[OUT_W-2:0]};
  endfunction

  logic [OUT_W-1:0] lut_rom [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam logic [OUT_W-1:0] ENTRY = lut_entry(g);
    assign lut_rom[g] = ENTRY;
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_act;
  logic [1:0]         amp_act;
  logic               wrap_p0;
  logic [PHASE_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, ftw_act};

  // Stage 0: accumulate; settings are only accepted on a wrap so periods stay whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      ftw_act <= ftw_lookup(reffreq);
      amp_act <= refampl;
      wrap_p0 <= 1'b0;
    end else begin
      acc     <= acc_sum[PHASE_W-1:0];
      wrap_p0 <= acc_sum[PHASE_W];
      if (acc_sum[PHASE_W]) begin
        ftw_act <= ftw_lookup(reffreq);
        amp_act <= refampl;
      end
    end
  end

  logic [TOP_W-1:0] sin_top;
  logic [TOP_W-1:0] cos_top;

`ifdef REF_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign sin_top = TOP_W'((acc + PHASE_W'(lfsr)) >> (PHASE_W - TOP_W));
`else
  assign sin_top = acc[PHASE_W-1 -: TOP_W];
`endif

  assign cos_top = sin_top + TOP_W'(LUT_N);

  logic [LUT_AW:0]         sin_fold_p1, cos_fold_p1;
  logic [1:0]              amp_p1, amp_p2, amp_p3;
  logic [OUT_W-1:0]        sin_mag_p2, cos_mag_p2;
  logic                    sin_neg_p2, cos_neg_p2;
  logic signed [OUT_W-1:0] sin_p3, cos_p3;
  logic                    vld_p1, vld_p2, vld_p3;
  logic                    wrap_p1, wrap_p2, wrap_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      wrap_p1 <= 1'b0;
      wrap_p2 <= 1'b0;
      wrap_p3 <= 1'b0;
    end else begin
      vld_p1  <= 1'b1;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      wrap_p1 <= wrap_p0;
      wrap_p2 <= wrap_p1;
      wrap_p3 <= wrap_p2;
    end
  end

  always_ff @(posedge clk) begin
    // Stage 1: quadrant fold
    sin_fold_p1 <= fold(sin_top);
    cos_fold_p1 <= fold(cos_top);
    amp_p1      <= amp_act;
    // Stage 2: ROM read
    sin_mag_p2  <= lut_rom[sin_fold_p1[LUT_AW-1:0]];
    cos_mag_p2  <= lut_rom[cos_fold_p1[LUT_AW-1:0]];
    sin_neg_p2  <= sin_fold_p1[LUT_AW];
    cos_neg_p2  <= cos_fold_p1[LUT_AW];
    amp_p2      <= amp_p1;
    // Stage 3: sign restore
    sin_p3      <= apply_sign(sin_mag_p2, sin_neg_p2);
    cos_p3      <= apply_sign(cos_mag_p2, cos_neg_p2);
    amp_p3      <= amp_p2;
  end

  logic signed [OUT_W-1:0] sin_att_p3;
  assign sin_att_p3 = attenuate(sin_p3, amp_p3);

  // Stage 4: outputs; refIO acts without waiting for a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_o   <= '0;
      cos_o   <= '0;
      dac_o   <= MIDSCALE;
      valid_o <= 1'b0;
      sync_o  <= 1'b0;
    end else begin
      valid_o <= vld_p3;
      sync_o  <= wrap_p3 & vld_p3;
      if (vld_p3) begin
        sin_o <= sin_att_p3;
        cos_o <= cos_p3;
      end
      dac_o <= (refIO && vld_p3) ? to_offset_bin(sin_att_p3) : MIDSCALE;
    end
  end

endmodule

// File: tb/tb_ref_dds_gen.sv
// Directed bench for ref_dds_gen: startup latency, sync spacing, peaks, attenuation, refIO, reset.
module tb_ref_dds_gen;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         reffreq;
  logic [1:0]         refampl;
  logic               refIO;
  logic signed [15:0] sin_o, cos_o;
  logic [15:0]        dac_o;
  logic               valid_o, sync_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int smax, smin, smax_n, smin_n, cmax, cmin, dmax, dmin, vlow, nsync;
  int sy [3];

  ref_dds_gen dut (
    .clk     (clk),
    .rst     (rst),
    .reffreq (reffreq),
    .refampl (refampl),
    .refIO   (refIO),
    .sin_o   (sin_o),
    .cos_o   (cos_o),
    .dac_o   (dac_o),
    .valid_o (valid_o),
    .sync_o  (sync_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    smax = -100000; smin = 100000; smax_n = 0; smin_n = 0;
    cmax = -100000; cmin = 100000; dmax = -1; dmin = 100000;
    vlow = 0; nsync = 0;
    for (int i = 0; i < 3; i++) sy[i] = -1;
  endtask

  // Steps n cycles; records sync positions and peaks within cycles lo..hi.
  task automatic scan(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      step();
      if (sync_o) begin
        if (nsync < 3) sy[nsync] = cyc;
        nsync++;
      end
      if (cyc >= lo && cyc <= hi) begin
        if (!valid_o) vlow++;
        if (int'(sin_o) > smax) begin smax = int'(sin_o); smax_n = 0; end
        if (int'(sin_o) == smax) smax_n++;
        if (int'(sin_o) < smin) begin smin = int'(sin_o); smin_n = 0; end
        if (int'(sin_o) == smin) smin_n++;
        if (int'(cos_o) > cmax) cmax = int'(cos_o);
        if (int'(cos_o) < cmin) cmin = int'(cos_o);
        if (int'(dac_o) > dmax) dmax = int'(dac_o);
        if (int'(dac_o) < dmin) dmin = int'(dac_o);
      end
    end
  endtask

  // Holds rst for n edges, checks the reset state, then releases.
  task automatic do_reset(input int n, input string tag);
    rst = 1'b1;
    repeat (n) step();
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_sin"},   sin_o,   0);
    check({tag, "_cos"},   cos_o,   0);
    check({tag, "_dac"},   dac_o,   16'h8000);
    check({tag, "_sync"},  sync_o,  0);
    rst = 1'b0;
    cyc = 0;
  endtask

  // reffreq=5, refampl=0, refIO=1 startup: three invalid cycles, then the phase-0 sample.
  task automatic startup(input string tag);
    for (int i = 1; i <= 3; i++) begin
      step();
      check({tag, "_valid_low"}, valid_o, 0);
    end
    step();
    check({tag, "_valid_hi"}, valid_o, 1);
    check({tag, "_sin0"},     sin_o,   101);
    check({tag, "_cos0"},     cos_o,   32767);
    check({tag, "_dac0"},     dac_o,   16'h8065);
  endtask

  logic signed [15:0] neg_pk;
  logic signed [15:0] att_min;
  logic [15:0]        dac_min_exp;

  initial begin
    rst = 1'b1; reffreq = 3'd5; refampl = 2'd0; refIO = 1'b1;

    do_reset(2, "rst1");
    startup("start1");

    // 100 kHz: 300-cycle periods, full-scale peaks once each
    reffreq = 3'd7; refampl = 2'd0;
    do_reset(1, "rst2");
    clear_stats();
    scan(910, 4, 303);
    check("f7_valid_gaps", vlow, 0);
    check("f7_sync1", sy[0], 304);
    check("f7_spacing1", sy[1] - sy[0], 300);
    check("f7_spacing2", sy[2] - sy[1], 300);
    check("f7_sin_max", smax, 32767);
    check("f7_sin_min", smin, -32767);
    check("f7_max_hits", smax_n, 1);
    check("f7_min_hits", smin_n, 1);

    // 1/8 amplitude: sine shifted arithmetically, cosine untouched
    refampl = 2'd3;
    do_reset(1, "rst3");
    clear_stats();
    scan(304, 4, 303);
    neg_pk      = -16'sd32767;
    att_min     = neg_pk >>> 3;
    dac_min_exp = {~att_min[15], att_min[14:0]};
    check("a3_sin_max", smax, 4095);
    check("a3_sin_min", smin, int'(att_min));
    check("a3_cos_max", cmax, 32767);
    check("a3_cos_min", cmin, -32767);
    check("a3_dac_max", dmax, 16'h8FFF);
    check("a3_dac_min", dmin, int'(dac_min_exp));

    // refIO drop parks the DAC at once; sample 75 still carries +4095
    do_reset(1, "rst4");
    repeat (76) step();
    refIO = 1'b0;
    step();
    check("io_park1", dac_o, 16'h8000);
    step();
    check("io_park2", dac_o, 16'h8000);
    check("io_valid", valid_o, 1);
    refIO = 1'b1;
    step();
    check("io_sin_peak", sin_o, 4095);
    check("io_dac_peak", dac_o, 16'h8FFF);

    // Single-cycle reset mid-period replays the startup sequence
    reffreq = 3'd5; refampl = 2'd0; refIO = 1'b1;
    do_reset(1, "rst5");
    startup("start2");

    // 1 kHz -> 10 kHz mid-period: change waits for the wrap
    do_reset(1, "rst6");
    clear_stats();
    scan(100, 0, -1);
    reffreq = 3'd6;
    scan(32910, 0, -1);
    check("fchg_sync1", sy[0], 30004);
    check("fchg_spacing", sy[1] - sy[0], 3000);
    check("fchg_count", nsync, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
